// File: rtl/spawn_scheduler.sv
// Two-requester spawn-location scheduler: samples a free-running LFSR, range-checks
// each sample against the playfield and grants one validated (or fallback) coordinate.
module spawn_scheduler #(
    parameter int unsigned X_MIN      = 16,
    parameter int unsigned X_MAX      = 623,
    parameter int unsigned Y_MIN      = 16,
    parameter int unsigned Y_MAX      = 239,
    parameter int unsigned MAX_TRIES  = 8,
    parameter int unsigned FALLBACK_X = 320,
    parameter int unsigned FALLBACK_Y = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lfsr_x,
    input  logic [9:0]  lfsr_y,
    input  logic [1:0]  req,
    output logic [1:0]  ack,
    output logic [10:0] loc_x,
    output logic [9:0]  loc_y,
    output logic        fallback,
    output logic        busy
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned TW = 4;

    localparam logic [XW-1:0] X_MIN_T  = XW'(X_MIN);
    localparam logic [XW-1:0] X_MAX_T  = XW'(X_MAX);
    localparam logic [YW-1:0] Y_MIN_T  = YW'(Y_MIN);
    localparam logic [YW-1:0] Y_MAX_T  = YW'(Y_MAX);
    localparam logic [XW-1:0] FB_X_T   = XW'(FALLBACK_X);
    localparam logic [YW-1:0] FB_Y_T   = YW'(FALLBACK_Y);
    localparam logic [TW-1:0] TRIES_T  = TW'(MAX_TRIES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SAMPLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] GRANT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_q, rr_d;
    logic [TW-1:0] tries_q, tries_d;
    logic [XW-1:0] cand_x_q, cand_x_d;
    logic [YW-1:0] cand_y_q, cand_y_d;
    logic [1:0]    ack_d;
    logic [XW-1:0] loc_x_d;
    logic [YW-1:0] loc_y_d;
    logic          fallback_d;
    logic          busy_d;
    logic          in_range;

    assign in_range = (cand_x_q >= X_MIN_T) && (cand_x_q <= X_MAX_T) &&
                      (cand_y_q >= Y_MIN_T) && (cand_y_q <= Y_MAX_T);

    // Next-state and registered-output decode; ack is staged so it is high exactly in GRANT.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        tries_d    = tries_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        ack_d      = 2'b00;
        loc_x_d    = loc_x;
        loc_y_d    = loc_y;
        fallback_d = fallback;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_d = (req == 2'b11) ? rr_q : req[1];
                    tries_d = '0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                cand_x_d = lfsr_x;
                cand_y_d = lfsr_y;
                tries_d  = tries_q + TW'(1);
                state_d  = CHECK;
            end
            CHECK: begin
                if (in_range) begin
                    loc_x_d    = cand_x_q;
                    loc_y_d    = cand_y_q;
                    fallback_d = 1'b0;
                    ack_d      = owner_q ? 2'b10 : 2'b01;
                    state_d    = GRANT;
                end else if (tries_q == TRIES_T) begin
                    loc_x_d    = FB_X_T;
                    loc_y_d    = FB_Y_T;
                    fallback_d = 1'b1;
                    ack_d      = owner_q ? 2'b10 : 2'b01;
                    state_d    = GRANT;
                end else begin
                    state_d = SAMPLE;
                end
            end
            GRANT: begin
                rr_d    = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            tries_q  <= '0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            ack      <= 2'b00;
            loc_x    <= '0;
            loc_y    <= '0;
            fallback <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            tries_q  <= tries_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            ack      <= ack_d;
            loc_x    <= loc_x_d;
            loc_y    <= loc_y_d;
            fallback <= fallback_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: vector table plus hand sequences, checked by a grant scoreboard.
module tb_spawn_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] lfsr_x;
    logic [9:0]  lfsr_y;
    logic [1:0]  req;
    logic [1:0]  ack;
    logic [10:0] loc_x;
    logic [9:0]  loc_y;
    logic        fallback;
    logic        busy;

    spawn_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lfsr_x   (lfsr_x),
        .lfsr_y   (lfsr_y),
        .req      (req),
        .ack      (ack),
        .loc_x    (loc_x),
        .loc_y    (loc_y),
        .fallback (fallback),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Latency is counted in edges from the edge after which the request was driven.
    typedef struct {
        logic [1:0]  ack;
        logic [10:0] x;
        logic [9:0]  y;
        logic        fb;
        int          start;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  req;
        logic [10:0] lx;
        logic [9:0]  ly;
        logic [1:0]  ack;
        logic [10:0] ex;
        logic [9:0]  ey;
        logic        fb;
        int          lat;
    } vec_t;

    exp_t sb[$];
    logic [1:0] prev_ack = 2'b00;
    vec_t vec[11];

    task automatic check(input string name, input longint act, input longint req_v);
        n_checks++;
        if (act != req_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input logic [1:0] a, input int x, input int y,
                                input logic fb, input int lat);
        exp_t e;
        e.ack   = a;
        e.x     = 11'(x);
        e.y     = 10'(y);
        e.fb    = fb;
        e.start = cyc;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ack == 2'b00 && k < 40);
        if (ack == 2'b00) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: no ack after %0d cycles", name, k);
        end
    endtask

    // Grant monitor: every ack pulse is matched against the oldest expected grant.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ack != 2'b00) begin
            check("ack_onehot", longint'($onehot(ack)), 1);
            check("busy_with_ack", busy, 1);
            check("ack_not_consecutive", prev_ack, 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got %b expected none (cycle %0d)", ack, cyc);
            end else begin
                e = sb.pop_front();
                check("grant_ack", ack, e.ack);
                check("grant_loc_x", loc_x, e.x);
                check("grant_loc_y", loc_y, e.y);
                check("grant_fallback", fallback, e.fb);
                check("grant_latency", cyc - e.start, e.lat);
            end
        end
        prev_ack <= ack;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        vec[0]  = '{2'b01, 11'd100,  10'd50,   2'b01, 11'd100, 10'd50,  1'b0, 3};
        vec[1]  = '{2'b11, 11'd16,   10'd16,   2'b10, 11'd16,  10'd16,  1'b0, 3};
        vec[2]  = '{2'b11, 11'd623,  10'd239,  2'b01, 11'd623, 10'd239, 1'b0, 3};
        vec[3]  = '{2'b10, 11'd624,  10'd100,  2'b10, 11'd320, 10'd120, 1'b1, 17};
        vec[4]  = '{2'b01, 11'd300,  10'd239,  2'b01, 11'd300, 10'd239, 1'b0, 3};
        vec[5]  = '{2'b01, 11'd15,   10'd100,  2'b01, 11'd320, 10'd120, 1'b1, 17};
        vec[6]  = '{2'b10, 11'd300,  10'd15,   2'b10, 11'd320, 10'd120, 1'b1, 17};
        vec[7]  = '{2'b10, 11'd300,  10'd240,  2'b10, 11'd320, 10'd120, 1'b1, 17};
        vec[8]  = '{2'b11, 11'd623,  10'd16,   2'b01, 11'd623, 10'd16,  1'b0, 3};
        vec[9]  = '{2'b10, 11'd2000, 10'd1000, 2'b10, 11'd320, 10'd120, 1'b1, 17};
        vec[10] = '{2'b01, 11'd16,   10'd239,  2'b01, 11'd16,  10'd239, 1'b0, 3};

        rst_n  = 1'b0;
        req    = 2'b11;
        lfsr_x = 11'd100;
        lfsr_y = 10'd50;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", ack, 0);
        check("reset_busy", busy, 0);
        check("reset_loc_x", loc_x, 0);
        check("reset_loc_y", loc_y, 0);
        check("reset_fallback", fallback, 0);

        // Release with a tie pending: requester 0 wins, then strict alternation.
        step();
        rst_n = 1'b1;
        expect_grant(2'b01, 100, 50, 1'b0, 3);
        wait_ack("reset_release");
        for (int i = 0; i < 3; i++) begin
            step();
            req = (i % 2 == 0) ? 2'b10 : 2'b01;
            expect_grant(req, 100, 50, 1'b0, 3);
            step();
            req = 2'b11;
            wait_ack("round_robin");
        end
        step();
        req = 2'b00;

        for (int i = 0; i < 11; i++) begin
            step();
            req    = vec[i].req;
            lfsr_x = vec[i].lx;
            lfsr_y = vec[i].ly;
            expect_grant(vec[i].ack, int'(vec[i].ex), int'(vec[i].ey), vec[i].fb, vec[i].lat);
            wait_ack("vector");
            step();
            req = 2'b00;
        end

        // One rejection, then an accepted sample at the far corner.
        step();
        req    = 2'b01;
        lfsr_x = 11'd15;
        lfsr_y = 10'd50;
        expect_grant(2'b01, 623, 239, 1'b0, 5);
        step();
        step();
        lfsr_x = 11'd623;
        lfsr_y = 10'd239;
        wait_ack("reject_accept");
        step();
        req = 2'b00;

        // Reset while the request sits in CHECK: it must vanish without an ack.
        step();
        req    = 2'b10;
        lfsr_x = 11'd100;
        lfsr_y = 10'd50;
        expect_grant(2'b10, 100, 50, 1'b0, 3);
        step();
        step();
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midreset_ack", ack, 0);
        check("midreset_busy", busy, 0);
        check("midreset_loc_x", loc_x, 0);
        repeat (3) step();
        rst_n = 1'b1;
        expect_grant(2'b10, 100, 50, 1'b0, 3);
        wait_ack("after_midreset");
        step();
        req = 2'b00;

        repeat (4) step();
        check("scoreboard_empty", sb.size(), 0);
        check("idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
